// File: rtl/hex_scroller_if.sv
// rtl/hex_scroller_if.sv - control/window bundle between a message source and hex_scroller
interface hex_scroller_if #(
  parameter int MSG_LEN = 16
);
  localparam int PW = $clog2(MSG_LEN);

  logic [4*MSG_LEN-1:0] msg;
  logic                 load;
  logic                 run;
  logic                 step;
  logic                 dir;
  logic [3:0]           seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  logic [PW-1:0]        pos;

  modport master (
    output msg, load, run, step, dir,
    input  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, pos
  );

  modport slave (
    input  msg, load, run, step, dir,
    output seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, pos
  );
endinterface

// File: rtl/hex_scroller.sv
// rtl/hex_scroller.sv - circular 8-digit marquee window over a hex message
module hex_scroller #(
  parameter int MSG_LEN  = 16,
  parameter int TICK_DIV = 50000000
) (
  input  logic           ck,
  input  logic           rst,
  hex_scroller_if.slave  bus
);
  localparam int PW = $clog2(MSG_LEN);
  localparam int SW = PW + 1;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] POS_LAST = PW'(MSG_LEN - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] LEN_W    = SW'(MSG_LEN);

  typedef enum logic {STOPPED, RUNNING} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [PW-1:0]        pos_q, pos_d;
  logic [4*MSG_LEN-1:0] msg_q;
  logic [3:0]           win_q [8];
  logic [3:0]           win_d [8];
  logic [3:0]           nib [MSG_LEN];
  logic                 tick, advance;

  // nibble k of the stored message, nibble 0 being the leftmost literal digit
  for (genvar k = 0; k < MSG_LEN; k++) begin : g_nib
    assign nib[k] = msg_q[4*(MSG_LEN-1-k) +: 4];
  end

  // tick/advance decode and the next position, wrapped modulo MSG_LEN explicitly
  always_comb begin
    tick    = (state_q == RUNNING) && (cnt_q == CNT_LAST);
    advance = tick || ((state_q == STOPPED) && bus.step);
    pos_d   = pos_q;
    if (bus.dir) begin
      pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
    end else begin
      pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
    end
  end

  // window digit i shows nibble (pos+i) mod MSG_LEN; the sum never reaches 2*MSG_LEN
  always_comb begin
    logic [SW-1:0] sum;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum = {1'b0, pos_q} + SW'(i);
      if (sum >= LEN_W) begin
        sum = sum - LEN_W;
      end
      win_d[i] = nib[sum[PW-1:0]];
    end
  end

  // run/stop FSM, prescaler, position and registered window; load beats any advance
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= STOPPED;
      cnt_q   <= '0;
      pos_q   <= '0;
      msg_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        win_q[i] <= win_d[i];
      end
      case (state_q)
        STOPPED: begin
          cnt_q <= '0;
          if (bus.run) begin
            state_q <= RUNNING;
          end
        end
        RUNNING: begin
          if (!bus.run) begin
            state_q <= STOPPED;
            cnt_q   <= '0;
          end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= STOPPED;
          cnt_q   <= '0;
        end
      endcase
      if (bus.load) begin
        msg_q <= bus.msg;
        pos_q <= '0;
        cnt_q <= '0;
      end else if (advance) begin
        pos_q <= pos_d;
      end
    end
  end

  assign bus.seg7 = win_q[0];
  assign bus.seg6 = win_q[1];
  assign bus.seg5 = win_q[2];
  assign bus.seg4 = win_q[3];
  assign bus.seg3 = win_q[4];
  assign bus.seg2 = win_q[5];
  assign bus.seg1 = win_q[6];
  assign bus.seg0 = win_q[7];
  assign bus.pos  = pos_q;

endmodule

// File: tb/tb_hex_scroller.sv
// tb/tb_hex_scroller.sv - vectors, corner sequences and a reference model for hex_scroller
module tb_hex_scroller;
  logic ck = 1'b0;
  logic rst_a, rst_b;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 ck = ~ck;

  hex_scroller_if #(.MSG_LEN(16)) ifa ();
  hex_scroller_if #(.MSG_LEN(10)) ifb ();

  hex_scroller #(.MSG_LEN(16), .TICK_DIV(4)) dut_a (.ck(ck), .rst(rst_a), .bus(ifa.slave));
  hex_scroller #(.MSG_LEN(10), .TICK_DIV(2)) dut_b (.ck(ck), .rst(rst_b), .bus(ifb.slave));

  localparam logic [63:0] MSG_A  = 64'hE5D00814_0123ABCD;
  localparam logic [63:0] MSG_A2 = 64'h01234567_89ABCDEF;

  // reference model for the 16-nibble, 4-clock instance
  bit         m_run;
  int         m_age;
  int         m_pos;
  logic [3:0] m_msg [16];
  logic [31:0] m_seg;

  function automatic logic [31:0] segs_a();
    return {ifa.seg7, ifa.seg6, ifa.seg5, ifa.seg4, ifa.seg3, ifa.seg2, ifa.seg1, ifa.seg0};
  endfunction

  function automatic logic [31:0] segs_b();
    return {ifb.seg7, ifb.seg6, ifb.seg5, ifb.seg4, ifb.seg3, ifb.seg2, ifb.seg1, ifb.seg0};
  endfunction

  // window of message 0123456789 starting at digit p: digit value equals its index
  function automatic logic [31:0] win10(input int p);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w = (w << 4) | 32'((p + i) % 10);
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_a(input bit r, input bit ld, input bit rn, input bit st, input bit dr,
                         input logic [63:0] mg);
    logic [31:0] w;
    logic [63:0] t;
    bit tk, adv;
    if (r) begin
      m_run = 0; m_age = 0; m_pos = 0; m_seg = '0;
      for (int k = 0; k < 16; k++) m_msg[k] = '0;
      return;
    end
    w = '0;
    for (int i = 0; i < 8; i++) w = (w << 4) | {28'd0, m_msg[(m_pos + i) % 16]};
    tk  = m_run && (m_age % 4 == 3);
    adv = tk || (!m_run && st);
    if (ld) begin
      t = mg;
      for (int k = 0; k < 16; k++) begin
        m_msg[k] = t[63:60];
        t = t << 4;
      end
      m_pos = 0;
    end else if (adv) begin
      m_pos = (m_pos + (dr ? 15 : 1)) % 16;
    end
    m_age = (m_run && rn && !ld) ? m_age + 1 : 0;
    m_run = rn;
    m_seg = w;
  endtask

  task automatic cyc_a(input bit r, input bit ld, input bit rn, input bit st, input bit dr,
                       input logic [63:0] mg);
    rst_a = r; ifa.load = ld; ifa.run = rn; ifa.step = st; ifa.dir = dr; ifa.msg = mg;
    @(posedge ck);
    model_a(r, ld, rn, st, dr, mg);
    #1;
  endtask

  task automatic cyc_b(input bit r, input bit ld, input bit rn);
    rst_b = r; ifb.load = ld; ifb.run = rn; ifb.step = 1'b0; ifb.dir = 1'b0;
    ifb.msg = 40'h01234_56789;
    @(posedge ck);
    #1;
  endtask

  typedef struct {
    bit r, ld, rn, st, dr;
    int pos;
    logic [31:0] seg;
  } vec_t;

  vec_t tbl [18];

  initial begin
    bit run_v, dir_v;
    tbl[0]  = '{1, 0, 0, 0, 0, 0,  32'h0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0,  32'h0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0,  32'h0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0,  32'h0};
    tbl[4]  = '{0, 1, 0, 0, 0, 0,  32'h0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0,  32'hE5D00814};
    tbl[6]  = '{0, 0, 1, 0, 0, 0,  32'hE5D00814};
    tbl[7]  = '{0, 0, 1, 0, 0, 0,  32'hE5D00814};
    tbl[8]  = '{0, 0, 1, 0, 0, 0,  32'hE5D00814};
    tbl[9]  = '{0, 0, 1, 0, 0, 0,  32'hE5D00814};
    tbl[10] = '{0, 0, 1, 0, 0, 1,  32'hE5D00814};
    tbl[11] = '{0, 0, 1, 0, 0, 1,  32'h5D008140};
    tbl[12] = '{0, 0, 0, 0, 0, 1,  32'h5D008140};
    tbl[13] = '{0, 0, 0, 1, 1, 0,  32'h5D008140};
    tbl[14] = '{0, 0, 0, 1, 1, 15, 32'hE5D00814};
    tbl[15] = '{0, 0, 0, 0, 0, 15, 32'hDE5D0081};
    tbl[16] = '{0, 0, 0, 1, 0, 0,  32'hDE5D0081};
    tbl[17] = '{0, 0, 0, 0, 0, 0,  32'hE5D00814};

    rst_b = 1'b1; ifb.load = 0; ifb.run = 0; ifb.step = 0; ifb.dir = 0; ifb.msg = '0;

    for (int i = 0; i < 18; i++) begin
      cyc_a(tbl[i].r, tbl[i].ld, tbl[i].rn, tbl[i].st, tbl[i].dr, MSG_A);
      check($sformatf("tbl%0d_pos", i), 32'(ifa.pos), 32'(tbl[i].pos));
      check($sformatf("tbl%0d_seg", i), segs_a(), tbl[i].seg);
    end

    // step ignored while running, then load landing on the tick cycle
    cyc_a(0, 0, 1, 0, 0, MSG_A);
    for (int i = 0; i < 3; i++) begin
      cyc_a(0, 0, 1, 1, 0, MSG_A);
      check("step_in_run", 32'(ifa.pos), 32'd0);
    end
    cyc_a(0, 1, 1, 0, 0, MSG_A2);
    check("load_on_tick", 32'(ifa.pos), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc_a(0, 0, 1, 0, 0, MSG_A2);
      check("tick_after_load_hold", 32'(ifa.pos), 32'd0);
      if (i == 0) check("load_new_msg", segs_a(), 32'h01234567);
    end
    cyc_a(0, 0, 1, 0, 0, MSG_A2);
    check("tick_after_load", 32'(ifa.pos), 32'd1);

    // scroll forward to the last nibble and across the wrap
    repeat (56) cyc_a(0, 0, 1, 0, 0, MSG_A2);
    check("reach_15", 32'(ifa.pos), 32'd15);
    cyc_a(0, 0, 1, 0, 0, MSG_A2);
    check("win_at_15", segs_a(), 32'hF0123456);
    repeat (3) cyc_a(0, 0, 1, 0, 0, MSG_A2);
    check("wrap_15_0", 32'(ifa.pos), 32'd0);

    // randomized traffic against the model
    run_v = 1'b1;
    dir_v = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) run_v = ~run_v;
      if ($urandom_range(0, 19) == 0) dir_v = ~dir_v;
      cyc_a($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0, run_v,
            $urandom_range(0, 3) == 0, dir_v, {$urandom, $urandom});
      check("rand_pos", 32'(ifa.pos), 32'(m_pos));
      check("rand_seg", segs_a(), m_seg);
    end

    // ten-nibble instance with a two-clock prescaler
    rst_a = 1'b1;
    cyc_b(1, 0, 0);
    cyc_b(1, 0, 0);
    check("b_reset_pos", 32'(ifb.pos), 32'd0);
    check("b_reset_seg", segs_b(), 32'h0);
    cyc_b(0, 1, 0);
    check("b_load_pos", 32'(ifb.pos), 32'd0);
    cyc_b(0, 0, 1);
    for (int c = 1; c <= 40; c++) begin
      cyc_b(0, 0, 1);
      check($sformatf("b_pos_c%0d", c), 32'(ifb.pos), 32'((c / 2) % 10));
      check($sformatf("b_seg_c%0d", c), segs_b(), win10(((c - 1) / 2) % 10));
      if (((c - 1) / 2) % 10 == 5) check("b_win_at_5", segs_b(), 32'h56789012);
    end
    cyc_b(1, 0, 1);
    check("b_midrun_rst_pos", 32'(ifb.pos), 32'd0);
    check("b_midrun_rst_seg", segs_b(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
